main_memory: RTL

Block-granular main-memory responder behind the direct-mapped cache. It serves 128-bit (16-byte) block reads on cache misses and whole-block write-through updates from the cache. It replaces the zero-latency combinational memory model with a clocked one that has a valid/ready handshake, configurable access latency and backpressure. The address space is 1 KiB, organised as 64 blocks of 16 bytes.

---
 rtl/main_memory.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : Block-granular main-memory responder for the direct-mapped
//               cache. Serves whole-block reads and write-through block
//               updates over a valid/ready handshake. Each access takes
//               LATENCY cycles. The response is held under backpressure.
//               Optional feature macro: MEM_STATS_EN adds saturating
//               read/write access counters (rd_count, wr_count).
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_row,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_write_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_row,
    output logic [BLOCK_W-1:0] resp_read_data
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    localparam int         c_BYTES  = BLOCK_W / 8;
    localparam int         c_OFF_W  = $clog2(c_BYTES);
    localparam int         c_IDX_W  = ADDR_W - c_OFF_W;
    localparam int         c_NBLK   = 1 << c_IDX_W;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_count;
    logic                 r_row;
    logic [c_IDX_W-1:0]   r_blk;
    logic [BLOCK_W-1:0]   r_wdata;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic                 r_resp_row;
    logic [BLOCK_W-1:0]   r_resp_data;

    logic                 w_access;
    logic                 w_mem_we;
    logic [BLOCK_W-1:0]   w_blocks [c_NBLK];
    logic                 w_unused_offset;

    // Byte offset inside a block is irrelevant: all transfers are whole blocks.
    assign w_unused_offset = ^req_addr[c_OFF_W-1:0];

    // The access edge is the last WAIT cycle; the array is only touched there.
    assign w_access = (r_state == S_WAIT) && (r_count == 4'd0);
    assign w_mem_we = w_access && r_row;

    // Reset image: every byte holds the low 8 bits of its own byte address.
    function automatic logic [BLOCK_W-1:0] f_init_block(input int blk);
        logic [BLOCK_W-1:0] v;
        v = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            v[8*i +: 8] = 8'(blk * c_BYTES + i);
        end
        return v;
    endfunction

    // One register per block so each gets its own constant reset image.
    generate
        for (genvar g = 0; g < c_NBLK; g++) begin : g_blk
            localparam logic [BLOCK_W-1:0] c_INIT = f_init_block(g);
            logic [BLOCK_W-1:0] r_data;

            // Block storage: reinitialise on reset, update on a write access.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= c_INIT;
                end else if (w_mem_we && (r_blk == c_IDX_W'(g))) begin
                    r_data <= r_wdata;
                end
            end

            assign w_blocks[g] = r_data;
        end
    endgenerate

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= 4'd0;
            r_row        <= 1'b0;
            r_blk        <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_row   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_row       <= req_row;
                        r_blk       <= req_addr[ADDR_W-1:c_OFF_W];
                        r_wdata     <= req_write_data;
                        r_count     <= c_LAT_M1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        // Writes echo the block they just stored.
                        r_resp_data  <= r_row ? r_wdata : w_blocks[r_blk];
                        r_resp_row   <= r_row;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Response data is kept after the handshake; only valid drops.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_row       = r_resp_row;
    assign resp_read_data = r_resp_data;

`ifdef MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Saturating access counters, bumped on the access edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (w_access) begin
            if (r_row) begin
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end else begin
                if (r_rd_count != 16'hFFFF) begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule
`default_nettype wire
